spiflash_responder: RTL and testbench
=====================================

Name: spiflash_responder

Overview:
- Synthesizable SPI flash responder: the target side of the single-bit (mode 0, MSB-first) SPI flash read protocol issued by the SoC flash controller.
- Oversamples the SPI pins in the system clock domain, decodes commands, and fetches bytes from a local memory over a req/ack port.
- Used as an on-chip/FPGA stand-in for the external flash in memory and boot tests.
- Supports READ (0x03) with 24-bit address and continuous sequential streaming; all other commands are accepted and ignored.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (csb, sck, io0); legal 2..3.
- ADDR_BITS, 24, address width; fixed by protocol, always 24.

Ports:
- clk  input  1  system clock; frequency >= 8x spi_sck.
- reset  input  1  synchronous, active-high reset.
- spi_csb  input  1  chip select, active low.
- spi_sck  input  1  SPI clock, idle low.
- spi_io0  input  1  MOSI, sampled on rising sck.
- spi_io1  output  1  MISO, updated on falling sck.
- spi_io1_oe  output  1  MISO output enable.
- mem_addr  output  24  byte address for fetch.
- mem_req  output  1  fetch request, held until ack.
- mem_ack  input  1  fetch complete; mem_rdata valid this cycle.
- mem_rdata  input  8  fetched byte.
- cmd_code  output  8  last complete command byte received.
- busy  output  1  high whenever state != IDLE.
- err_underrun  output  1  sticky; set when a byte was not ready in time.

Behaviour:
- Reset: state IDLE; spi_io1=0, spi_io1_oe=0, mem_req=0, mem_addr=0, cmd_code=0, busy=0, err_underrun=0; synchronizers cleared with csb=1, sck=0. Reset mid-transaction aborts immediately.
- Inputs pass through SYNC_STAGES flops. Rise/fall detection on synchronized sck drives all protocol events, so edge-to-action latency is SYNC_STAGES+1 clk.
- States:
  - IDLE: wait for synced csb=0 -> CMD, bit counter=0.
  - CMD: shift io0 on each sck rise. On the 8th bit, cmd_code is updated. Command 0x03 -> ADDR; any other command -> IGNORE.
  - ADDR: shift 24 bits MSB-first. On the 24th rise, load mem_addr and go to FETCH; mem_req is asserted the next clk.
  - FETCH: hold mem_req with mem_addr stable. On mem_ack: load the tx shift register from mem_rdata, drop mem_req, increment mem_addr (wraps 0xFFFFFF -> 0x000000), go to DATA.
  - DATA: spi_io1_oe=1. On each sck fall, drive the next bit, bit 7 first.
    - Prefetch: after each tx-register load, immediately re-assert mem_req for mem_addr; the ack is stored in a one-byte holding buffer.
    - On the fall that starts a new byte, load from the holding buffer if full. If empty, load 0xFF, set err_underrun, and the pending request keeps running; its data goes to the following byte.
  - IGNORE: io1_oe=0; wait for csb high.
- First data bit is driven on the first sck fall after the 24th address rise. If FETCH has not been acked by then, the underrun rule applies: 0xFF is sent and err_underrun is set.
- Synced csb rising in any state: return to IDLE next clk. mem_req drops, io1_oe=0, io1=0, counters clear, holding buffer emptied, and any in-flight ack is discarded. err_underrun and cmd_code are retained.
- csb rise and sck edge in the same clk: csb wins and the edge is ignored.
- mem_ack while mem_req=0 is ignored.
- The master may deassert csb at any bit boundary, including mid-byte or mid-address; no partial effects remain except cmd_code when 8 command bits were completed.
- err_underrun clears only on reset.

Test Plan:
- Memory preloaded with addr N -> data N[7:0], ack 1 clk after req. Master sends 0x03, 0x000010, then clocks 4 bytes -> io1 yields 0x10,0x11,0x12,0x13; cmd_code=0x03; err_underrun=0; busy returns to 0 within 3 clk of csb high.
- Read at 0xFFFFFE, 4 bytes -> data from 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; mem_addr wrap observed.
- Master sends 0xAB then 8 more sck cycles -> cmd_code=0xAB, io1_oe stays 0, no mem_req; a following 0x03 read at 0x000020 returns 0x20.
- Memory ack delayed 40 clk with sck = clk/8 -> first byte 0xFF, err_underrun=1 and held through later transactions until reset.
- csb raised after 12 address bits; then a fresh read at 0x000005 -> no mem_req on the aborted transfer; new read returns 0x05.
- reset asserted mid-DATA -> all outputs 0 next clk; subsequent read operates normally.

Source files
------------

// File: rtl/spiflash_responder_if.sv
// Byte-fetch port between the SPI flash responder and the memory that backs it.
interface spiflash_responder_if;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/spiflash_responder.sv
// SPI flash target (mode 0, single-bit READ 0x03) oversampled in the system clock domain,
// streaming bytes fetched from a local memory with a one-byte prefetch buffer.
module spiflash_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_csb,
  input  logic                 spi_sck,
  input  logic                 spi_io0,
  output logic                 spi_io1,
  output logic                 spi_io1_oe,
  spiflash_responder_if.master mem,
  output logic [7:0]           cmd_code,
  output logic                 busy,
  output logic                 err_underrun
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, FETCH, DATA, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] csb_sync_reg;
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] io0_sync_reg;
  logic                   sck_d_reg;
  logic                   csb_s, sck_s, io0_s, sck_rise, sck_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      csb_sync_reg <= '1;
      sck_sync_reg <= '0;
      io0_sync_reg <= '0;
      sck_d_reg    <= 1'b0;
    end else begin
      csb_sync_reg <= {csb_sync_reg[SYNC_STAGES-2:0], spi_csb};
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
      io0_sync_reg <= {io0_sync_reg[SYNC_STAGES-2:0], spi_io0};
      sck_d_reg    <= sck_s;
    end
  end

  assign csb_s    = csb_sync_reg[SYNC_STAGES-1];
  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign io0_s    = io0_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_reg;
  assign sck_fall = ~sck_s & sck_d_reg;

  state_t                 state_reg, state_next;
  logic [4:0]             cnt_reg, cnt_next;
  logic [ADDR_BITS-2:0]   shift_reg, shift_next;
  logic [7:0]             tx_reg, tx_next;
  logic                   first_reg, first_next;
  logic [7:0]             hold_reg, hold_next;
  logic                   hold_full_reg, hold_full_next;
  logic                   req_reg, req_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic                   io1_reg, io1_next;
  logic [7:0]             cmd_reg, cmd_next;
  logic                   err_reg, err_next;
  logic [7:0]             byte_sel;
  logic [7:0]             cmd_byte;
  logic                   ack_ok;

  assign ack_ok   = mem.mem_ack & req_reg;
  assign cmd_byte = {shift_reg[6:0], io0_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      tx_reg        <= '0;
      first_reg     <= 1'b0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      req_reg       <= 1'b0;
      addr_reg      <= '0;
      io1_reg       <= 1'b0;
      cmd_reg       <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      tx_reg        <= tx_next;
      first_reg     <= first_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      req_reg       <= req_next;
      addr_reg      <= addr_next;
      io1_reg       <= io1_next;
      cmd_reg       <= cmd_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    tx_next        = tx_reg;
    first_next     = first_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    req_next       = req_reg;
    addr_next      = addr_reg;
    io1_next       = io1_reg;
    cmd_next       = cmd_reg;
    err_next       = err_reg;
    byte_sel       = 8'hFF;

    if (state_reg == IDLE) begin
      if (!csb_s) begin
        state_next = CMD;
        cnt_next   = '0;
      end
    end else if (csb_s) begin
      // Deselect wins over any same-cycle sck edge or ack; only cmd_code/err survive.
      state_next     = IDLE;
      cnt_next       = '0;
      shift_next     = '0;
      tx_next        = '0;
      first_next     = 1'b0;
      hold_full_next = 1'b0;
      req_next       = 1'b0;
      io1_next       = 1'b0;
    end else begin
      case (state_reg)
        CMD: begin
          if (sck_rise) begin
            shift_next = {shift_reg[ADDR_BITS-3:0], io0_s};
            cnt_next   = cnt_reg + 5'd1;
            if (cnt_reg == 5'd7) begin
              cmd_next   = cmd_byte;
              cnt_next   = '0;
              state_next = (cmd_byte == 8'h03) ? ADDR : IGNORE;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            shift_next = {shift_reg[ADDR_BITS-3:0], io0_s};
            cnt_next   = cnt_reg + 5'd1;
            if (cnt_reg == 5'(ADDR_BITS - 1)) begin
              addr_next  = {shift_reg, io0_s};
              cnt_next   = '0;
              req_next   = 1'b1;
              state_next = FETCH;
            end
          end
        end
        FETCH: begin
          if (ack_ok) begin
            req_next  = 1'b0;
            addr_next = addr_reg + ADDR_BITS'(1);
          end
          if (sck_fall) begin
            // First bit is due before the fetch completed: send 0xFF, keep the request.
            byte_sel   = ack_ok ? mem.mem_rdata : 8'hFF;
            err_next   = err_reg | ~ack_ok;
            io1_next   = byte_sel[7];
            tx_next    = {byte_sel[6:0], 1'b0};
            cnt_next   = 5'd1;
            state_next = DATA;
          end else if (ack_ok) begin
            tx_next    = mem.mem_rdata;
            first_next = 1'b1;
            state_next = DATA;
          end
        end
        DATA: begin
          if (!hold_full_reg && !req_reg)
            req_next = 1'b1;
          if (ack_ok) begin
            req_next       = 1'b0;
            addr_next      = addr_reg + ADDR_BITS'(1);
            hold_next      = mem.mem_rdata;
            hold_full_next = 1'b1;
          end
          if (sck_fall) begin
            if (cnt_reg[2:0] == 3'd0) begin
              if (first_reg) begin
                byte_sel   = tx_reg;
                first_next = 1'b0;
              end else if (hold_full_reg) begin
                byte_sel       = hold_reg;
                hold_full_next = 1'b0;
              end else if (ack_ok) begin
                byte_sel       = mem.mem_rdata;
                hold_full_next = 1'b0;
              end else begin
                err_next = 1'b1;
              end
              io1_next = byte_sel[7];
              tx_next  = {byte_sel[6:0], 1'b0};
            end else begin
              io1_next = tx_reg[7];
              tx_next  = {tx_reg[6:0], 1'b0};
            end
            cnt_next = {2'b00, cnt_reg[2:0] + 3'd1};
          end
        end
        default: ;
      endcase
    end
  end

  assign spi_io1      = io1_reg;
  assign spi_io1_oe   = (state_reg == DATA);
  assign busy         = (state_reg != IDLE);
  assign mem.mem_req  = req_reg;
  assign mem.mem_addr = addr_reg;
  assign cmd_code     = cmd_reg;
  assign err_underrun = err_reg;

endmodule

// File: tb/tb_spiflash_responder.sv
// Directed bench for spiflash_responder: SPI master tasks, a memory returning addr[7:0],
// and a per-cycle compare process against the bench's own expectations.
module tb_spiflash_responder;
  localparam int H = 4;  // clk cycles per sck half period (sck = clk/8)

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_csb = 1'b1;
  logic spi_sck = 1'b0;
  logic spi_io0 = 1'b0;
  logic spi_io1, spi_io1_oe, busy, err_underrun;
  logic [7:0] cmd_code;

  spiflash_responder_if mem_if ();

  spiflash_responder #(.SYNC_STAGES(2), .ADDR_BITS(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_csb      (spi_csb),
    .spi_sck      (spi_sck),
    .spi_io0      (spi_io0),
    .spi_io1      (spi_io1),
    .spi_io1_oe   (spi_io1_oe),
    .mem          (mem_if),
    .cmd_code     (cmd_code),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic req_ok = 1'b0;
  logic oe_ok = 1'b0;
  logic err_known = 1'b1;
  logic exp_err = 1'b0;
  logic saw_zero = 1'b0;
  logic [23:0] exp_fetch_addr = 24'd0;
  int mem_delay = 1;
  int wcnt = 0;
  logic [7:0] rx_buf [0:3];
  logic [7:0] v;
  logic r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data = addr[7:0], ack mem_delay cycles after req; model tracks next fetch address.
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mem_if.mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_if.mem_ack) begin
        mem_if.mem_ack = 1'b0;
        exp_fetch_addr = exp_fetch_addr + 24'd1;
        wcnt = 0;
      end else if (mem_if.mem_req) begin
        wcnt++;
        if (wcnt >= mem_delay) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_if.mem_addr[7:0];
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Per-cycle compare against the bench's model of what is allowed/expected.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!req_ok) chk("req_when_not_reading", 32'(mem_if.mem_req), 32'd0);
        if (mem_if.mem_req) begin
          chk("fetch_addr", 32'(mem_if.mem_addr), 32'(exp_fetch_addr));
          if (mem_if.mem_addr == 24'd0) saw_zero = 1'b1;
        end
        if (!oe_ok) chk("oe_when_not_reading", 32'(spi_io1_oe), 32'd0);
        if (err_known) chk("err_underrun", 32'(err_underrun), 32'(exp_err));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic spi_bit(input logic b, output logic rb);
    spi_io0 = b;
    repeat (H) @(negedge clk);
    spi_sck = 1'b1;
    rb = spi_io1;
    repeat (H) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], rb);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, rb);
      b[i] = rb;
    end
    chk("io1_oe_during_data", 32'(spi_io1_oe), 32'd1);
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (H) @(negedge clk);
    spi_csb = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_after_csb", 32'(busy), 32'd0);
    chk("req_after_csb", 32'(mem_if.mem_req), 32'd0);
    chk("oe_after_csb", 32'(spi_io1_oe), 32'd0);
    req_ok = 1'b0;
    oe_ok  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Expected stream: byte i comes from address a+i; after a first-byte underrun the
  // first byte is 0xFF and every following byte shifts back by one address.
  task automatic read_txn(input logic [23:0] a, input int n, input logic uflag);
    logic [23:0] ea;
    logic [7:0]  e;
    logic [7:0]  got;
    exp_fetch_addr = a;
    spi_begin();
    send_byte(8'h03);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    req_ok = 1'b1;
    oe_ok  = 1'b1;
    send_byte(a[7:0]);
    for (int i = 0; i < n; i++) begin
      recv_byte(got);
      rx_buf[i] = got;
      ea = a + 24'(i) - (uflag ? 24'd1 : 24'd0);
      e  = (uflag && i == 0) ? 8'hFF : ea[7:0];
      chk("rx_byte", 32'(got), 32'(e));
    end
    spi_end();
    chk("cmd_code_read", 32'(cmd_code), 32'h03);
    $display("read addr=%06h bytes=%0d first=%02h err=%0b", a, n, rx_buf[0], err_underrun);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk("rst_io1", 32'(spi_io1), 32'd0);
    chk("rst_oe", 32'(spi_io1_oe), 32'd0);
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("rst_cmd", 32'(cmd_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    read_txn(24'h000010, 4, 1'b0);
    chk("lit_byte0_0x10", 32'(rx_buf[0]), 32'h10);
    chk("lit_byte3_0x13", 32'(rx_buf[3]), 32'h13);

    saw_zero = 1'b0;
    read_txn(24'hFFFFFE, 4, 1'b0);
    chk("lit_wrap_byte1", 32'(rx_buf[1]), 32'hFF);
    chk("lit_wrap_byte2", 32'(rx_buf[2]), 32'h00);
    chk("addr_wrap_seen", 32'(saw_zero), 32'd1);

    spi_begin();
    send_byte(8'hAB);
    send_byte(8'h5A);
    spi_end();
    chk("cmd_code_ignored", 32'(cmd_code), 32'hAB);
    $display("ignored cmd=%02h", cmd_code);
    read_txn(24'h000020, 1, 1'b0);
    chk("lit_after_ignore", 32'(rx_buf[0]), 32'h20);

    mem_delay = 40;
    err_known = 1'b0;
    read_txn(24'h000030, 3, 1'b1);
    chk("lit_underrun_ff", 32'(rx_buf[0]), 32'hFF);
    chk("lit_underrun_next", 32'(rx_buf[1]), 32'h30);
    chk("err_set", 32'(err_underrun), 32'd1);
    mem_delay = 1;
    exp_err   = 1'b1;
    err_known = 1'b1;

    spi_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
    spi_end();
    $display("aborted read after 12 address bits");
    read_txn(24'h000005, 1, 1'b0);
    chk("lit_after_abort", 32'(rx_buf[0]), 32'h05);

    spi_begin();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    exp_fetch_addr = 24'h000007;
    req_ok = 1'b1;
    oe_ok  = 1'b1;
    send_byte(8'h07);
    recv_byte(v);
    chk("pre_reset_byte", 32'(v), 32'h07);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
    @(negedge clk);
    reset   = 1'b1;
    spi_csb = 1'b1;
    exp_err = 1'b0;
    @(negedge clk);
    chk("mid_rst_io1", 32'(spi_io1), 32'd0);
    chk("mid_rst_oe", 32'(spi_io1_oe), 32'd0);
    chk("mid_rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("mid_rst_addr", 32'(mem_if.mem_addr), 32'd0);
    chk("mid_rst_cmd", 32'(cmd_code), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err_underrun), 32'd0);
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    req_ok = 1'b0;
    oe_ok  = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset applied mid-data");
    read_txn(24'h000042, 2, 1'b0);
    chk("lit_after_reset", 32'(rx_buf[1]), 32'h43);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
